// File: rtl/fetch_stage.sv
// IF stage and IF/ID pipeline register of the 5-stage MIPS core.
// Define IF_HALT_DETECT_EN to stop fetching on the all-ones halt word.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   input  logic [1:0]  pc_src,
   input  logic [31:0] jr_target,
   input  logic        enable_IF,
   input  logic        enable_ID,
   input  logic        reset_ID,
   output logic [31:0] instr_ID,
   output logic [31:0] pc_plus4_ID,
   output logic        valid_ID,
   output logic        halted
);

`ifdef IF_HALT_DETECT_EN
   typedef enum logic [1:0] {
      ST_BOOT,
      ST_FETCH,
      ST_HALT
   } state_t;
`else
   typedef enum logic [0:0] {
      ST_BOOT,
      ST_FETCH
   } state_t;
`endif

   state_t      state;
   logic [31:0] pc_q;
   logic [31:0] pc_plus4;
   logic [31:0] jump_tgt;
   logic [31:0] branch_off;
   logic [31:0] branch_tgt;
   logic [31:0] redirect_tgt;
   logic        pc_en;
   logic        redirect;
   logic        in_fetch;
   logic        fetching;
   logic        halt_hit;

   assign imem_addr  = pc_q;
   assign pc_plus4   = pc_q + 32'd4;

   assign jump_tgt   = {pc_plus4_ID[31:28],
                        instr_ID[25:0], 2'b00};
   assign branch_off = {{14{instr_ID[15]}},
                        instr_ID[15:0], 2'b00};
   assign branch_tgt = pc_plus4_ID + branch_off;

   always_comb begin
      redirect_tgt = pc_plus4;
      unique case (pc_src)
         2'd0: redirect_tgt = pc_plus4;
         2'd1: redirect_tgt = jump_tgt;
         2'd2: redirect_tgt = jr_target;
         2'd3: redirect_tgt = branch_tgt;
      endcase
   end

   // PC only moves when IF/ID can also accept; the
   // enable_IF-without-enable_ID combination just holds.
   assign pc_en    = enable_IF & enable_ID;
   assign in_fetch = (state == ST_FETCH);
   assign redirect = enable_IF & (pc_src != 2'd0);
   assign fetching = in_fetch & imem_ready;

`ifdef IF_HALT_DETECT_EN
   assign halt_hit = fetching & pc_en & ~redirect &
                     (imem_rdata == 32'hFFFF_FFFF);
`else
   assign halt_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_BOOT;
         imem_req <= 1'b0;
         halted   <= 1'b0;
      end else begin
         unique case (state)
            ST_BOOT: begin
               state    <= ST_FETCH;
               imem_req <= 1'b1;
            end
            ST_FETCH: begin
`ifdef IF_HALT_DETECT_EN
               if (halt_hit) begin
                  state    <= ST_HALT;
                  imem_req <= 1'b0;
                  halted   <= 1'b1;
               end
`endif
            end
`ifdef IF_HALT_DETECT_EN
            ST_HALT: begin
               imem_req <= 1'b0;
               halted   <= 1'b1;
            end
`endif
            default: begin
               state    <= ST_BOOT;
               imem_req <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= RESET_PC;
      end else if (pc_en && in_fetch) begin
         if (redirect) begin
            pc_q <= redirect_tgt;
         end else if (fetching && !halt_hit) begin
            pc_q <= pc_plus4;
         end
      end
   end

   // A redirect squashes whatever word came back this
   // cycle: it belongs to the wrong path.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_ID    <= NOP_INSTR;
         pc_plus4_ID <= 32'd0;
         valid_ID    <= 1'b0;
      end else if (reset_ID) begin
         instr_ID    <= NOP_INSTR;
         valid_ID    <= 1'b0;
      end else if (!enable_ID) begin
         instr_ID    <= instr_ID;
         valid_ID    <= valid_ID;
      end else if (redirect) begin
         instr_ID    <= NOP_INSTR;
         valid_ID    <= 1'b0;
      end else if (fetching && !halt_hit) begin
         instr_ID    <= imem_rdata;
         pc_plus4_ID <= pc_plus4;
         valid_ID    <= 1'b1;
      end else begin
         instr_ID    <= NOP_INSTR;
         valid_ID    <= 1'b0;
      end
   end

endmodule
